// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random wait, stimulus LED, millisecond BCD count, cheat/timeout detection.
// Button events act on the edge that first samples them high; led/mode trail the state register by one cycle.
module reaction_timer_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int RAND_BITS    = 12,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        stop_in,
  input  logic        clear_in,
  output logic        led,
  output logic [15:0] bcd,
  output logic [2:0]  mode
);

  localparam int TICK_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int DELAY_MAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
  localparam int DELAY_W   = (DELAY_MAX > 0) ? $clog2(DELAY_MAX + 1) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_MS - 1);
  localparam logic [DELAY_W-1:0] DELAY_MIN = DELAY_W'(MIN_DELAY_MS);

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);

  // Ripple the +1 through the digits; a digit at 9 wraps to 0 and carries on.
  function automatic logic [15:0] bcd_inc(input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    r = b;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_TIMING  = 3'd2,
    S_DONE    = 3'd3,
    S_CHEAT   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t             state;
  logic               start_q, stop_q, clear_q;
  logic               start_ev, stop_ev, clear_ev;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [TICK_W-1:0]  tick_cnt;
  logic               running;
  logic               tick;
  logic [DELAY_W-1:0] delay_cnt;
  logic [DELAY_W-1:0] delay_load;
  logic [15:0]        bcd_next;

  assign start_ev = start_in & ~start_q;
  assign stop_ev  = stop_in  & ~stop_q;
  assign clear_ev = clear_in & ~clear_q;

  // Taps 16,14,13,11 in right-shift form; a non-zero seed keeps it off the all-zero lockup.
  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign delay_load = DELAY_MIN + DELAY_W'(lfsr[RAND_BITS-1:0]);

  assign running  = (state == S_WAIT) || (state == S_TIMING);
  assign tick     = running && (tick_cnt == TICK_LAST);
  assign bcd_next = bcd_inc(bcd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clear_q   <= 1'b0;
      lfsr      <= 16'hACE1;
      tick_cnt  <= '0;
      delay_cnt <= '0;
      bcd       <= 16'h0000;
      led       <= 1'b0;
      mode      <= 3'd0;
    end else begin
      start_q <= start_in;
      stop_q  <= stop_in;
      clear_q <= clear_in;
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      led     <= (state == S_TIMING);
      mode    <= state;

      if (!running || tick) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + TICK_W'(1);

      if (clear_ev) begin
        state    <= S_IDLE;
        bcd      <= 16'h0000;
        tick_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            // stop outranks start even though it has nothing to do here
            if (start_ev && !stop_ev) begin
              state     <= S_WAIT;
              delay_cnt <= delay_load;
              tick_cnt  <= '0;
            end
          end
          S_WAIT: begin
            if (stop_ev) begin
              state    <= S_CHEAT;
              bcd      <= 16'h9999;
              tick_cnt <= '0;
            end else if (tick) begin
              if (delay_cnt <= DELAY_W'(1)) begin
                state    <= S_TIMING;
                bcd      <= 16'h0000;
                tick_cnt <= '0;
              end else begin
                delay_cnt <= delay_cnt - DELAY_W'(1);
              end
            end
          end
          S_TIMING: begin
            // A tick landing with stop is dropped so the frozen value is what the player saw.
            if (stop_ev) begin
              state    <= S_DONE;
              tick_cnt <= '0;
            end else if (tick) begin
              bcd <= bcd_next;
              if (bcd_next == TIMEOUT_BCD) begin
                state    <= S_TIMEOUT;
                tick_cnt <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomised bench for reaction_timer_ctrl against an arithmetic model of the timing rules.
module tb_reaction_timer_ctrl;

  localparam int TPM   = 4;
  localparam int MIN_D = 3;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_in = 1'b0, stop_in = 1'b0, clear_in = 1'b0;
  logic        led;
  logic [15:0] bcd;
  logic [2:0]  mode;
  logic        start2 = 1'b0, stop2 = 1'b0, clear2 = 1'b0;
  logic        led2;
  logic [15:0] bcd2;
  logic [2:0]  mode2;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr;

  reaction_timer_ctrl #(.TICKS_PER_MS(TPM), .MIN_DELAY_MS(MIN_D), .RAND_BITS(2), .TIMEOUT_MS(TMO)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in), .clear_in(clear_in),
    .led(led), .bcd(bcd), .mode(mode)
  );

  reaction_timer_ctrl #(.TICKS_PER_MS(TPM), .MIN_DELAY_MS(MIN_D), .RAND_BITS(1), .TIMEOUT_MS(1000)) dut2 (
    .clk(clk), .rst(rst), .start_in(start2), .stop_in(stop2), .clear_in(clear2),
    .led(led2), .bcd(bcd2), .mode(mode2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int x, b;
    x = int'(v);
    b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (b << 15));
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    return 16'((v / 1000 % 10) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic start_run(output int d);
    d = MIN_D + int'(m_lfsr) % 4;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (led !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL led_rise: led=%b after %0d clks, required 1", led, n);
    end
  endtask

  task automatic clear_pulse;
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 1'b0 || bcd !== 16'h0000 || mode !== 3'd0) begin
      errors++;
      $display("FAIL reset_held: led=%b bcd=%h mode=%0d, required 0/0000/0", led, bcd, mode);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (led !== 1'b0 || bcd !== 16'h0000 || mode !== 3'd0 || mode2 !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: led=%b bcd=%h mode=%0d mode2=%0d, required 0/0000/0/0", led, bcd, mode, mode2);
    end
  endtask

  task automatic test_start_wait;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    checks++;
    if (mode !== 3'd1 || led !== 1'b0) begin
      errors++;
      $display("FAIL start_wait: mode=%0d led=%b, required 1/0", mode, led);
    end
    clear_pulse();
    checks++;
    if (mode !== 3'd0 || bcd !== 16'h0000) begin
      errors++;
      $display("FAIL wait_clear: mode=%0d bcd=%h, required 0/0000", mode, bcd);
    end
  endtask

  task automatic test_normal_run;
    int d, n, changed;
    start_run(d);
    wait_led(n);
    repeat (28) @(negedge clk);
    stop_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mode !== 3'd3 || bcd !== 16'h0007 || led !== 1'b0) begin
      errors++;
      $display("FAIL normal_done: mode=%0d bcd=%h led=%b, required 3/0007/0", mode, bcd, led);
    end
    changed = 0;
    repeat (20) begin
      @(negedge clk);
      if (mode !== 3'd3 || bcd !== 16'h0007 || led !== 1'b0) changed++;
    end
    checks++;
    if (changed != 0) begin
      errors++;
      $display("FAIL stop_held: %0d cycles changed, required 0 (mode=%0d bcd=%h)", changed, mode, bcd);
    end
    stop_in = 1'b0;
    clear_pulse();
    checks++;
    if (mode !== 3'd0 || bcd !== 16'h0000) begin
      errors++;
      $display("FAIL done_clear: mode=%0d bcd=%h, required 0/0000", mode, bcd);
    end
  endtask

  task automatic test_delay;
    int d, n, cyc;
    cyc = 0;
    while (int'(m_lfsr) % 4 != 2 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (int'(m_lfsr) % 4 != 2) begin
      errors++;
      $display("FAIL seed_probe: slice=%0d after %0d clks, required 2", int'(m_lfsr) % 4, cyc);
    end
    start_run(d);
    wait_led(n);
    checks++;
    if (n < 4 * d - 1 || n > 4 * d + 1) begin
      errors++;
      $display("FAIL delay_slice2: led after %0d clks, required %0d +-1", n, 4 * d);
    end
    clear_pulse();
  endtask

  task automatic test_cheat;
    int d, saw;
    saw = 0;
    start_run(d);
    repeat (4) begin
      @(negedge clk);
      if (led === 1'b1) saw++;
    end
    stop_in = 1'b1;
    @(negedge clk);
    stop_in = 1'b0;
    @(negedge clk);
    checks++;
    if (mode !== 3'd4 || bcd !== 16'h9999) begin
      errors++;
      $display("FAIL cheat: mode=%0d bcd=%h, required 4/9999", mode, bcd);
    end
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (led === 1'b1) saw++;
    end
    checks++;
    if (mode !== 3'd4 || bcd !== 16'h9999 || saw != 0) begin
      errors++;
      $display("FAIL cheat_start_ignored: mode=%0d bcd=%h led_high=%0d, required 4/9999/0", mode, bcd, saw);
    end
    clear_pulse();
    checks++;
    if (mode !== 3'd0 || bcd !== 16'h0000) begin
      errors++;
      $display("FAIL cheat_clear: mode=%0d bcd=%h, required 0/0000", mode, bcd);
    end
  endtask

  task automatic test_timeout;
    int d, cyc, prev;
    logic [15:0] last;
    start_run(d);
    cyc = 0;
    while (mode !== 3'd2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mode !== 3'd2) begin
      errors++;
      $display("FAIL timing_entry: mode=%0d, required 2", mode);
    end
    prev = 0;
    last = bcd;
    cyc = 0;
    while (mode !== 3'd5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bcd !== last) begin
        checks++;
        if (bcd !== ref_bcd(prev + 1)) begin
          errors++;
          $display("FAIL count_step: bcd=%h, required %h", bcd, ref_bcd(prev + 1));
        end
        prev++;
        last = bcd;
      end
    end
    checks++;
    if (mode !== 3'd5 || bcd !== 16'h0020 || led !== 1'b0 || prev != TMO) begin
      errors++;
      $display("FAIL timeout: mode=%0d bcd=%h led=%b steps=%0d, required 5/0020/0/%0d", mode, bcd, led, prev, TMO);
    end
    clear_pulse();
  endtask

  task automatic test_carry;
    int cyc, prev, bad;
    logic [15:0] last, carry_val;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (mode2 !== 3'd2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mode2 !== 3'd2) begin
      errors++;
      $display("FAIL carry_entry: mode2=%0d, required 2", mode2);
    end
    prev = 0;
    bad = 0;
    last = bcd2;
    carry_val = 16'hxxxx;
    cyc = 0;
    while (mode2 !== 3'd5 && cyc < 4300) begin
      @(negedge clk);
      cyc++;
      if (bcd2 !== last) begin
        if (bcd2 !== ref_bcd(prev + 1)) bad++;
        if (prev == 999) carry_val = bcd2;
        prev++;
        last = bcd2;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL carry_sequence: %0d wrong steps, required 0", bad);
    end
    checks++;
    if (carry_val !== 16'h1000) begin
      errors++;
      $display("FAIL carry_0999: next=%h, required 1000", carry_val);
    end
    checks++;
    if (mode2 !== 3'd5 || bcd2 !== 16'h1000) begin
      errors++;
      $display("FAIL timeout_1000: mode2=%0d bcd2=%h, required 5/1000", mode2, bcd2);
    end
    clear2 = 1'b1;
    @(negedge clk);
    clear2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear_stop;
    int d, n;
    start_run(d);
    wait_led(n);
    repeat (6) @(negedge clk);
    stop_in = 1'b1;
    clear_in = 1'b1;
    @(negedge clk);
    stop_in = 1'b0;
    clear_in = 1'b0;
    @(negedge clk);
    checks++;
    if (mode !== 3'd0 || bcd !== 16'h0000 || led !== 1'b0) begin
      errors++;
      $display("FAIL clear_beats_stop: mode=%0d bcd=%h led=%b, required 0/0000/0", mode, bcd, led);
    end
  endtask

  task automatic test_async_reset;
    int d, n, w, en;
    start_run(d);
    wait_led(n);
    repeat (9) @(negedge clk);
    checks++;
    if (led !== 1'b1 || mode !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_timing: led=%b mode=%0d, required 1/2", led, mode);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (led !== 1'b0 || bcd !== 16'h0000 || mode !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: led=%b bcd=%h mode=%0d, required 0/0000/0", led, bcd, mode);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_run(d);
    wait_led(n);
    w = $urandom_range(8, 40);
    repeat (w) @(negedge clk);
    stop_in = 1'b1;
    @(negedge clk);
    stop_in = 1'b0;
    @(negedge clk);
    en = (w + 1) / TPM;
    checks++;
    if (mode !== 3'd3 || bcd !== ref_bcd(en)) begin
      errors++;
      $display("FAIL post_reset_run: mode=%0d bcd=%h, required 3/%h", mode, bcd, ref_bcd(en));
    end
    clear_pulse();
  endtask

  task automatic test_random;
    int d, n, w, c, en, emode;
    logic [15:0] ebcd;
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      start_run(d);
      if ($urandom_range(0, 3) == 0) begin
        c = $urandom_range(0, 4 * d - 2);
        repeat (c) @(negedge clk);
        stop_in = 1'b1;
        @(negedge clk);
        stop_in = 1'b0;
        @(negedge clk);
        checks++;
        if (mode !== 3'd4 || bcd !== 16'h9999) begin
          errors++;
          $display("FAIL rand_cheat[%0d]: mode=%0d bcd=%h, required 4/9999", it, mode, bcd);
        end
      end else begin
        wait_led(n);
        checks++;
        if (n < 4 * d - 1 || n > 4 * d + 1) begin
          errors++;
          $display("FAIL rand_delay[%0d]: led after %0d clks, required %0d +-1", it, n, 4 * d);
        end
        w = $urandom_range(0, 90);
        repeat (w) @(negedge clk);
        stop_in = 1'b1;
        @(negedge clk);
        stop_in = 1'b0;
        @(negedge clk);
        en = (w + 1) / TPM;
        if (en >= TMO) begin
          emode = 5;
          ebcd = ref_bcd(TMO);
        end else begin
          emode = 3;
          ebcd = ref_bcd(en);
        end
        checks++;
        if (int'(mode) != emode || bcd !== ebcd) begin
          errors++;
          $display("FAIL rand_run[%0d]: mode=%0d bcd=%h, required %0d/%h (w=%0d)", it, mode, bcd, emode, ebcd, w);
        end
      end
      clear_pulse();
      checks++;
      if (mode !== 3'd0 || bcd !== 16'h0000) begin
        errors++;
        $display("FAIL rand_clear[%0d]: mode=%0d bcd=%h, required 0/0000", it, mode, bcd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_wait();
    test_normal_run();
    test_delay();
    test_cheat();
    test_timeout();
    test_carry();
    test_clear_stop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
